// File: rtl/apb_completer_regs.sv
// APB completer with eight word registers and programmable wait states.
// Exports CTRL and a write pulse; imports a live status word.
module apb_completer_regs #(
  parameter int WAIT_STATES = 1,
  parameter int WR_CNT_W    = 16
) (
  input  logic        pclk,
  input  logic        prst,
  input  logic [4:0]  paddr,
  input  logic        pselx,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  output logic        pready,
  output logic [31:0] prdata,
  input  logic [31:0] status_i,
  output logic [31:0] ctrl_o,
  output logic        wr_pulse_o
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;

  logic [0:0]          r_state;
  logic [3:0]          r_cnt;
  logic [4:0]          r_addr;
  logic                r_write;
  logic [31:0]         r_wdata;
  logic                r_pready;
  logic [31:0]         r_prdata;
  logic                r_pulse;
  logic [31:0]         r_ctrl;
  logic [31:0]         r_scratch;
  logic [31:0]         r_gp [4];
  logic [WR_CNT_W-1:0] r_wr_cnt;

  logic [4:0]  w_rd_addr;
  logic [31:0] w_rdata;
  logic [2:0]  w_idx;
  logic        w_aligned;

  // With zero wait states read data loads at the setup edge, so use the live address
  assign w_rd_addr = (r_state == S_IDLE) ? paddr : r_addr;
  assign w_idx     = r_addr[4:2];
  assign w_aligned = (r_addr[1:0] == 2'b00);

  always_comb begin
    w_rdata = '0;
    if (w_rd_addr[1:0] == 2'b00) begin
      unique case (w_rd_addr[4:2])
        3'd0:    w_rdata = r_ctrl;
        3'd1:    w_rdata = r_scratch;
        3'd2:    w_rdata = status_i;
        3'd3:    w_rdata = 32'(r_wr_cnt);
        default: w_rdata = r_gp[w_rd_addr[3:2]];
      endcase
    end
  end

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_write   <= 1'b0;
      r_wdata   <= '0;
      r_pready  <= 1'b0;
      r_prdata  <= '0;
      r_pulse   <= 1'b0;
      r_ctrl    <= '0;
      r_scratch <= '0;
      r_gp      <= '{default: '0};
      r_wr_cnt  <= '0;
    end else begin
      r_pulse <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (pselx && !penable) begin
            r_addr   <= paddr;
            r_write  <= pwrite;
            r_wdata  <= pwdata;
            r_cnt    <= 4'(WAIT_STATES);
            r_pready <= (WAIT_STATES == 0);
            if (WAIT_STATES == 0 && !pwrite) r_prdata <= w_rdata;
            r_state  <= S_ACCESS;
          end
        end
        default: begin
          if (!pselx) begin
            r_state  <= S_IDLE;
            r_pready <= 1'b0;
            r_prdata <= '0;
          end else if (penable && !r_pready) begin
            r_cnt    <= r_cnt - 4'd1;
            r_pready <= (r_cnt == 4'd1);
            if (r_cnt == 4'd1 && !r_write) r_prdata <= w_rdata;
          end else if (penable && r_pready) begin
            // RO targets drop the data but the write still counts and pulses
            if (r_write && w_aligned) begin
              r_pulse  <= 1'b1;
              r_wr_cnt <= r_wr_cnt + WR_CNT_W'(1);
              unique case (w_idx)
                3'd0:    r_ctrl    <= r_wdata;
                3'd1:    r_scratch <= r_wdata;
                3'd2, 3'd3: ;
                default: r_gp[w_idx[1:0]] <= r_wdata;
              endcase
            end
            r_pready <= 1'b0;
            r_prdata <= '0;
            r_state  <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign pready     = r_pready;
  assign prdata     = r_prdata;
  assign ctrl_o     = r_ctrl;
  assign wr_pulse_o = r_pulse;

endmodule

// File: tb/tb_apb_completer_regs.sv
// Bench for apb_completer_regs: three instances (0, 1 and 15 wait states),
// scoreboard on completed transfers against a register-map model.
module tb_apb_completer_regs;

  typedef struct {
    int          dut;
    bit          rd;
    logic [31:0] data;
  } exp_t;

  logic        pclk = 1'b0;
  logic        prst;
  logic [4:0]  paddr [3];
  logic        psel [3];
  logic        pen [3];
  logic        pwr [3];
  logic [31:0] pwd [3];
  logic [31:0] status;
  logic        pready_o [3];
  logic [31:0] prdata_o [3];
  logic [31:0] ctrl_o [3];
  logic        pulse_o [3];

  int errors = 0;
  int checks = 0;

  exp_t        sbq [$];
  logic [31:0] m_reg [3][8];
  longint      m_cnt [3];
  int          m_pulse_exp [3];
  int          m_pulse_seen [3];

  always #5 pclk = ~pclk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    apb_completer_regs #(
      .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 1 : 15)),
      .WR_CNT_W   (g == 0 ? 4 : 16)
    ) u_dut (
      .pclk      (pclk),
      .prst      (prst),
      .paddr     (paddr[g]),
      .pselx     (psel[g]),
      .penable   (pen[g]),
      .pwrite    (pwr[g]),
      .pwdata    (pwd[g]),
      .pready    (pready_o[g]),
      .prdata    (prdata_o[g]),
      .status_i  (status),
      .ctrl_o    (ctrl_o[g]),
      .wr_pulse_o(pulse_o[g])
    );
  end

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 1 : 15);
  endfunction

  function automatic int cw_of(input int d);
    return (d == 0) ? 4 : 16;
  endfunction

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_cnt[d] = 0;
      for (int i = 0; i < 8; i++) m_reg[d][i] = '0;
    end
  endtask

  // Register-map semantics: returns the read value of a completed access
  task automatic model_access(input int d, input bit wr, input logic [4:0] a,
                              input logic [31:0] wd, output logic [31:0] rd);
    int idx;
    rd  = '0;
    idx = int'(a[4:2]);
    if (a[1:0] != 2'b00) return;
    if (wr) begin
      m_cnt[d] = (m_cnt[d] + 1) % (64'd1 << cw_of(d));
      m_pulse_exp[d]++;
      if (idx != 2 && idx != 3) m_reg[d][idx] = wd;
    end else if (idx == 2) begin
      rd = status;
    end else if (idx == 3) begin
      rd = 32'(m_cnt[d]);
    end else begin
      rd = m_reg[d][idx];
    end
  endtask

  task automatic xfer(input int d, input bit wr, input logic [4:0] a,
                      input logic [31:0] wd, output int acyc);
    exp_t        e;
    logic [31:0] rd;
    model_access(d, wr, a, wd, rd);
    e.dut  = d;
    e.rd   = !wr;
    e.data = rd;
    sbq.push_back(e);
    @(negedge pclk);
    psel[d] = 1'b1; pen[d] = 1'b0;
    paddr[d] = a; pwr[d] = wr; pwd[d] = wd;
    @(negedge pclk);
    pen[d] = 1'b1;
    paddr[d] = 5'($urandom);
    pwd[d]   = $urandom;
    pwr[d]   = 1'($urandom);
    acyc = 1;
    while (!pready_o[d] && acyc < 40) begin
      @(negedge pclk);
      acyc++;
    end
    if (!pready_o[d]) chk(1'b0, "pready_timeout", 32'(acyc), 32'(ws_of(d) + 1));
  endtask

  task automatic idle(input int d);
    @(negedge pclk);
    psel[d] = 1'b0;
    pen[d]  = 1'b0;
  endtask

  task automatic pulse_chk(input int d, input string nm);
    repeat (2) @(negedge pclk);
    chk(m_pulse_seen[d] == m_pulse_exp[d], nm,
        32'(m_pulse_seen[d]), 32'(m_pulse_exp[d]));
  endtask

  always @(negedge pclk) begin
    exp_t e;
    #1;
    for (int d = 0; d < 3; d++) begin
      if (pulse_o[d]) m_pulse_seen[d]++;
      if (psel[d] && pen[d] && pready_o[d]) begin
        chk(sbq.size() > 0, "sb_unexpected", 32'(d), 32'hffffffff);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          chk(e.dut == d, "sb_dut", 32'(d), 32'(e.dut));
          chk(prdata_o[d] == (e.rd ? e.data : 32'h0), "sb_prdata",
              prdata_o[d], e.rd ? e.data : 32'h0);
        end
      end else if (!pready_o[d]) begin
        chk(prdata_o[d] == 32'h0, "prdata_not_ready", prdata_o[d], 32'h0);
      end
    end
  end

  initial begin
    int acyc;
    int d;
    int prev;
    logic [4:0] a;
    bit wr;

    prst = 1'b1;
    status = '0;
    for (int i = 0; i < 3; i++) begin
      psel[i] = 0; pen[i] = 0; pwr[i] = 0; paddr[i] = '0; pwd[i] = '0;
      m_pulse_exp[i] = 0; m_pulse_seen[i] = 0;
    end
    model_reset();
    repeat (3) @(negedge pclk);
    chk(pready_o[1] == 0, "rst_pready", 32'(pready_o[1]), 0);
    chk(ctrl_o[1] == 0, "rst_ctrl", ctrl_o[1], 0);
    chk(pulse_o[1] == 0, "rst_pulse", 32'(pulse_o[1]), 0);
    prst = 1'b0;

    // write CTRL with one wait state
    xfer(1, 1, 5'h00, 32'hA5A5_0001, acyc);
    chk(acyc == 2, "ws1_latency", 32'(acyc), 2);
    @(negedge pclk);
    psel[1] = 0; pen[1] = 0;
    chk(pulse_o[1] == 1, "pulse_high", 32'(pulse_o[1]), 1);
    chk(ctrl_o[1] == 32'hA5A5_0001, "ctrl_o", ctrl_o[1], 32'hA5A5_0001);
    @(negedge pclk);
    chk(pulse_o[1] == 0, "pulse_one_cycle", 32'(pulse_o[1]), 0);
    xfer(1, 0, 5'h0C, 0, acyc); idle(1);

    // STATUS read and dropped RO write
    status = 32'hDEAD_BEEF;
    xfer(1, 0, 5'h08, 0, acyc); idle(1);
    xfer(1, 1, 5'h08, 32'h1, acyc); idle(1);
    xfer(1, 0, 5'h08, 0, acyc); idle(1);
    xfer(1, 0, 5'h0C, 0, acyc); idle(1);
    pulse_chk(1, "pulse_count_ro");

    // unaligned
    xfer(1, 1, 5'h03, 32'hFFFF_FFFF, acyc);
    chk(acyc == 2, "unaligned_latency", 32'(acyc), 2);
    idle(1);
    xfer(1, 0, 5'h03, 0, acyc); idle(1);
    xfer(1, 0, 5'h00, 0, acyc); idle(1);
    xfer(1, 0, 5'h0C, 0, acyc); idle(1);
    pulse_chk(1, "pulse_count_unaligned");

    // abort during wait
    xfer(1, 1, 5'h10, 32'h11, acyc); idle(1);
    @(negedge pclk);
    psel[1] = 1; pen[1] = 0; paddr[1] = 5'h10; pwr[1] = 1; pwd[1] = 32'hBAD;
    @(negedge pclk);
    pen[1] = 1;
    @(negedge pclk);
    psel[1] = 0; pen[1] = 0;
    xfer(1, 0, 5'h10, 0, acyc); idle(1);
    pulse_chk(1, "pulse_count_abort");

    // 15 wait states, then reset mid-access
    xfer(2, 1, 5'h00, 32'h5555, acyc);
    chk(acyc == 16, "ws15_latency", 32'(acyc), 16);
    idle(2);
    @(negedge pclk);
    chk(ctrl_o[2] == 32'h5555, "ctrl_ws15", ctrl_o[2], 32'h5555);
    psel[2] = 1; pen[2] = 0; paddr[2] = 5'h04; pwr[2] = 1; pwd[2] = 32'h77;
    @(negedge pclk);
    pen[2] = 1;
    repeat (3) @(negedge pclk);
    #2 prst = 1'b1;
    #1;
    chk(pready_o[2] == 0, "rst_mid_pready", 32'(pready_o[2]), 0);
    chk(ctrl_o[2] == 0, "rst_mid_ctrl2", ctrl_o[2], 0);
    chk(ctrl_o[1] == 0, "rst_mid_ctrl1", ctrl_o[1], 0);
    chk(pulse_o[2] == 0, "rst_mid_pulse", 32'(pulse_o[2]), 0);
    psel[2] = 0; pen[2] = 0;
    model_reset();
    @(negedge pclk);
    prst = 1'b0;
    xfer(2, 0, 5'h04, 0, acyc); idle(2);
    xfer(2, 0, 5'h0C, 0, acyc); idle(2);
    pulse_chk(2, "pulse_count_reset");

    // back-to-back write then read
    xfer(1, 1, 5'h14, 32'h1234, acyc);
    xfer(1, 0, 5'h14, 0, acyc);
    chk(acyc == 2, "b2b_latency", 32'(acyc), 2);
    idle(1);

    // zero wait states and counter wrap on the 4-bit instance
    for (int i = 0; i < 16; i++) begin
      xfer(0, 1, {3'($urandom_range(4, 7)), 2'b00}, $urandom, acyc);
      chk(acyc == 1, "ws0_latency", 32'(acyc), 1);
    end
    xfer(0, 0, 5'h0C, 0, acyc); idle(0);
    pulse_chk(0, "pulse_count_wrap");

    // penable without setup
    @(negedge pclk);
    psel[1] = 1; pen[1] = 1; paddr[1] = 5'h00; pwr[1] = 1; pwd[1] = 32'hBEEF;
    repeat (3) begin
      @(negedge pclk);
      chk(pready_o[1] == 0, "no_setup_pready", 32'(pready_o[1]), 0);
    end
    psel[1] = 0; pen[1] = 0;
    xfer(1, 0, 5'h00, 0, acyc); idle(1);

    // randomized traffic
    prev = 1;
    for (int n = 0; n < 80; n++) begin
      d  = int'($urandom_range(0, 1));
      wr = 1'($urandom);
      a  = {3'($urandom), 2'b00};
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      if (d != prev || $urandom_range(0, 1) == 0) begin
        idle(prev);
        status = $urandom;
      end
      xfer(d, wr, a, $urandom, acyc);
      chk(acyc == ws_of(d) + 1, "rand_latency", 32'(acyc), 32'(ws_of(d) + 1));
      prev = d;
    end
    idle(prev);
    pulse_chk(0, "pulse_count_rand0");
    chk(m_pulse_seen[1] == m_pulse_exp[1], "pulse_count_rand1",
        32'(m_pulse_seen[1]), 32'(m_pulse_exp[1]));
    chk(sbq.size() == 0, "sb_leftover", 32'(sbq.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
